tim_ctrl: RTL

Configuration and sequencing controller for the timer unit. It sits between the datapath's timer-register writes and the `TIM` counter, and holds the control, status, prescaler and auto-reload registers with preload/shadow semantics. It runs the timer start/run/update/stop sequence and raises a maskable update interrupt toward the core.

---
 rtl/tim_ctrl_pkg.sv | 24 ++
 rtl/tim_ctrl_regs.sv | 117 +++++++++++
 rtl/tim_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/tim_ctrl_pkg.sv
// Shared types and constants for the timer controller: FSM states, register
// addresses and CR/SR bit positions.
package tim_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      RUN    = 2'd2,
      UPDATE = 2'd3
   } tim_ctrl_state_e;

   localparam logic [1:0] TIM_CR_ADDR  = 2'd0;
   localparam logic [1:0] TIM_PSC_ADDR = 2'd1;
   localparam logic [1:0] TIM_ARR_ADDR = 2'd2;
   localparam logic [1:0] TIM_SR_ADDR  = 2'd3;

   localparam int CR_CEN  = 0;
   localparam int CR_OPM  = 1;
   localparam int CR_ARPE = 2;
   localparam int CR_UIE  = 3;

   localparam int SR_UIF  = 0;

endpackage

// File: rtl/tim_ctrl_regs.sv
// Timer register file: CR/SR, PSC/ARR preload and active copies, write decode
// and read mux. CR.OPM exists only when TIM_CTRL_OPM_EN is defined.
import tim_ctrl_pkg::*;

module tim_ctrl_regs #(
   parameter int               CNT_W   = 16,
   parameter logic [CNT_W-1:0] ARR_RST = 16'hFFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [31:0]      wr_data,
   input  logic [1:0]       rd_addr,
   input  logic             idle_i,
   input  logic             update_i,
   input  logic             cen_clr_i,
   output logic [31:0]      rd_data,
   output logic             cen_start_o,
   output logic             cen_stop_o,
   output logic             opm_o,
   output logic [CNT_W-1:0] psc_o,
   output logic [CNT_W-1:0] arr_o,
   output logic             irq_o
);

   logic [3:0]       cr_q, cr_d;
   logic             uif_q, uif_d;
   logic             irq_q, irq_d;
   logic [CNT_W-1:0] psc_pre_q, psc_pre_d, psc_act_q, psc_act_d;
   logic [CNT_W-1:0] arr_pre_q, arr_pre_d, arr_act_q, arr_act_d;
   logic             wr_cr, wr_psc, wr_arr, wr_sr, immediate;

   wire unused_wdata = ^wr_data[31:CNT_W];

   assign wr_cr  = wr_en && (wr_addr == TIM_CR_ADDR);
   assign wr_psc = wr_en && (wr_addr == TIM_PSC_ADDR);
   assign wr_arr = wr_en && (wr_addr == TIM_ARR_ADDR);
   assign wr_sr  = wr_en && (wr_addr == TIM_SR_ADDR);

   // A zero reload period would never overflow, so such starts are refused.
   assign cen_start_o = wr_cr && wr_data[CR_CEN] && !cr_q[CR_CEN] && (arr_act_q != '0);
   assign cen_stop_o  = wr_cr && !wr_data[CR_CEN];
   assign immediate   = idle_i || !cr_q[CR_ARPE];

   always_comb begin
      cr_d      = cr_q;
      uif_d     = uif_q;
      psc_pre_d = psc_pre_q;
      psc_act_d = psc_act_q;
      arr_pre_d = arr_pre_q;
      arr_act_d = arr_act_q;
      if (wr_cr) begin
         cr_d[CR_CEN]  = wr_data[CR_CEN] && (cr_q[CR_CEN] || (arr_act_q != '0));
`ifdef TIM_CTRL_OPM_EN
         cr_d[CR_OPM]  = wr_data[CR_OPM];
`else
         cr_d[CR_OPM]  = 1'b0;
`endif
         cr_d[CR_ARPE] = wr_data[CR_ARPE];
         cr_d[CR_UIE]  = wr_data[CR_UIE];
      end
      if (cen_clr_i) cr_d[CR_CEN] = 1'b0;
      if (wr_psc) begin
         psc_pre_d = wr_data[CNT_W-1:0];
         if (immediate) psc_act_d = wr_data[CNT_W-1:0];
      end
      if (wr_arr) begin
         arr_pre_d = wr_data[CNT_W-1:0];
         if (immediate) arr_act_d = wr_data[CNT_W-1:0];
      end
      if (wr_sr && wr_data[SR_UIF]) uif_d = 1'b0;
      // Update copies the post-write preload, and its UIF set beats a clear.
      if (update_i) begin
         psc_act_d = psc_pre_d;
         arr_act_d = arr_pre_d;
         uif_d     = 1'b1;
      end
      irq_d = uif_d && cr_d[CR_UIE];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cr_q      <= '0;
         uif_q     <= 1'b0;
         irq_q     <= 1'b0;
         psc_pre_q <= '0;
         psc_act_q <= '0;
         arr_pre_q <= ARR_RST;
         arr_act_q <= ARR_RST;
      end else begin
         cr_q      <= cr_d;
         uif_q     <= uif_d;
         irq_q     <= irq_d;
         psc_pre_q <= psc_pre_d;
         psc_act_q <= psc_act_d;
         arr_pre_q <= arr_pre_d;
         arr_act_q <= arr_act_d;
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         TIM_CR_ADDR:  rd_data[3:0]       = cr_q;
         TIM_PSC_ADDR: rd_data[CNT_W-1:0] = psc_pre_q;
         TIM_ARR_ADDR: rd_data[CNT_W-1:0] = arr_pre_q;
         default:      rd_data[SR_UIF]    = uif_q;
      endcase
   end

   assign opm_o = cr_q[CR_OPM];
   assign psc_o = psc_act_q;
   assign arr_o = arr_act_q;
   assign irq_o = irq_q;

endmodule

// File: rtl/tim_ctrl.sv
// Timer controller top: start/run/update/stop sequencer around tim_ctrl_regs.
// One-pulse mode is built only when TIM_CTRL_OPM_EN is defined.
import tim_ctrl_pkg::*;

module tim_ctrl #(
   parameter int               CNT_W   = 16,
   parameter logic [CNT_W-1:0] ARR_RST = 16'hFFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [31:0]      wr_data,
   input  logic [1:0]       rd_addr,
   output logic [31:0]      rd_data,
   input  logic             tim_done,
   output logic             tim_en,
   output logic             tim_load,
   output logic [CNT_W-1:0] tim_psc,
   output logic [CNT_W-1:0] tim_arr,
   output logic             irq
);

   tim_ctrl_state_e state_q, state_d;
   logic            cen_start, cen_stop, opm, update, cen_clr, idle;

   tim_ctrl_regs #(.CNT_W(CNT_W), .ARR_RST(ARR_RST)) u_regs (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .idle_i      (idle),
      .update_i    (update),
      .cen_clr_i   (cen_clr),
      .rd_data     (rd_data),
      .cen_start_o (cen_start),
      .cen_stop_o  (cen_stop),
      .opm_o       (opm),
      .psc_o       (tim_psc),
      .arr_o       (tim_arr),
      .irq_o       (irq)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tim_en   = 1'b0;
      tim_load = 1'b0;
      update   = 1'b0;
      cen_clr  = 1'b0;
      idle     = 1'b0;
      case (state_q)
         IDLE: begin
            idle = 1'b1;
            if (cen_start) state_d = START;
         end
         START: begin
            tim_load = 1'b1;
            state_d  = cen_stop ? IDLE : RUN;
         end
         RUN: begin
            tim_en = 1'b1;
            if (cen_stop)      state_d = IDLE;
            else if (tim_done) state_d = UPDATE;
         end
         default: begin
            tim_en  = 1'b1;
            update  = 1'b1;
            cen_clr = opm;
            state_d = (cen_stop || opm) ? IDLE : RUN;
         end
      endcase
   end

endmodule
